// File: rtl/dt_pack_if.sv
// dt_pack_if: pixel-RAM read bus, packed-image write bus and the start/done
// control pair of the binarising packer, bundled for module ports.
//
// Handshake semantics (the only ones on this bus):
//   start    one-cycle pulse from the environment, acted on only while the
//            packer is idle or done; ignored at any other time.
//   done     level, high while the packer sits in DONE.
//   res_rd   read request with res_addr in the same cycle; the RAM returns
//            res_di in the following cycle. There is no ready or stall.
//   sti_wr   one-cycle write strobe; sti_addr/sti_do are meaningful only
//            while sti_wr=1. The sink must accept every strobe.
interface dt_pack_if;
  logic        start;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;

  // The packer masters both RAM buses and reports done.
  modport master (
    input  start, res_di,
    output done, res_rd, res_addr, sti_wr, sti_addr, sti_do
  );

  // Environment side: pulses start, serves reads, sinks writes.
  modport slave (
    output start, res_di,
    input  done, res_rd, res_addr, sti_wr, sti_addr, sti_do
  );
endinterface

// File: rtl/dt_pack.sv
// dt_pack: thresholds 16384 byte pixels and packs them, 16 per word, into
// 1024 16-bit words. Pixel 16*w+i lands in bit i of word w.
// Per word: 16 READ cycles issue the addresses, LAST catches the final
// pixel (RAM has one cycle of read latency), WRITE emits the word.
module dt_pack #(
  parameter logic [7:0] THRESH = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  dt_pack_if.master        bus,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LAST  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_nxt_state;
  logic [9:0]  r_word;
  logic [9:0]  w_nxt_word;
  logic [3:0]  r_pix;
  logic [3:0]  w_nxt_pix;
  logic [15:0] r_acc;
  logic        w_bit;

  // Unsigned compare of the pixel returned by the RAM this cycle.
  assign w_bit = (bus.res_di > THRESH);

  assign o_dbg_state = r_state;

  // Next-state and next-counter logic; word index only moves at WRITE exit
  // and only wraps back to zero through a restart.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_word  = r_word;
    w_nxt_pix   = r_pix;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_nxt_state = S_READ;
          w_nxt_word  = '0;
          w_nxt_pix   = '0;
        end
      end
      S_READ: begin
        if (r_pix == 4'd15) begin
          w_nxt_state = S_LAST;
        end else begin
          w_nxt_pix = r_pix + 4'd1;
        end
      end
      S_LAST: begin
        w_nxt_state = S_WRITE;
      end
      S_WRITE: begin
        if (r_word == 10'd1023) begin
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_state = S_READ;
          w_nxt_word  = r_word + 10'd1;
          w_nxt_pix   = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_pix   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_word  <= w_nxt_word;
      r_pix   <= w_nxt_pix;
    end
  end

  // Accumulator: cleared on READ 0, then each returning pixel i-1 is stored
  // during READ i; LAST stores pixel 15.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (r_state == S_READ) begin
      if (r_pix == 4'd0) begin
        r_acc <= '0;
      end else begin
        r_acc[r_pix - 4'd1] <= w_bit;
      end
    end else if (r_state == S_LAST) begin
      r_acc[15] <= w_bit;
    end
  end

  // Registered outputs, loaded from the next state so they line up with the
  // state they belong to. res_addr holds through LAST; sti_do picks up
  // pixel 15 directly since the accumulator only gets it on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.res_rd   <= 1'b0;
      bus.res_addr <= '0;
      bus.sti_wr   <= 1'b0;
      bus.sti_addr <= '0;
      bus.sti_do   <= '0;
      bus.done     <= 1'b0;
    end else begin
      bus.res_rd <= (w_nxt_state == S_READ);
      if (w_nxt_state == S_READ) begin
        bus.res_addr <= {w_nxt_word, w_nxt_pix};
      end
      bus.sti_wr <= (w_nxt_state == S_WRITE);
      if (w_nxt_state == S_WRITE) begin
        bus.sti_addr <= r_word;
        bus.sti_do   <= {w_bit, r_acc[14:0]};
      end
      bus.done <= (w_nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_dt_pack.sv
// Bench for dt_pack: three instances (THRESH 0, 0x80, 0xFF) share one pixel
// image and run in lockstep. A cycle-level reference timeline derived from
// the 16+1+1 cycle word schedule predicts every output; packed words come
// from thresholding the image directly.
module tb_dt_pack;

  localparam int N_DUT = 3;
  localparam logic [7:0] TH [N_DUT] = '{8'h00, 8'h80, 8'hFF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  logic [7:0] mem [16384];

  logic        mon_rd    [N_DUT];
  logic [13:0] mon_raddr [N_DUT];
  logic        mon_wr    [N_DUT];
  logic [9:0]  mon_waddr [N_DUT];
  logic [15:0] mon_do    [N_DUT];
  logic        mon_done  [N_DUT];
  logic [2:0]  mon_state [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    dt_pack_if bus ();

    dt_pack #(.THRESH(TH[g])) u_dut (
      .clk         (clk),
      .reset       (rst),
      .bus         (bus),
      .o_dbg_state (mon_state[g])
    );

    assign bus.start = start;

    // Synchronous pixel RAM: data returns one cycle after the request.
    always @(posedge clk) begin
      if (bus.res_rd) bus.res_di <= mem[bus.res_addr];
    end

    assign mon_rd[g]    = bus.res_rd;
    assign mon_raddr[g] = bus.res_addr;
    assign mon_wr[g]    = bus.sti_wr;
    assign mon_waddr[g] = bus.sti_addr;
    assign mon_do[g]    = bus.sti_do;
    assign mon_done[g]  = bus.done;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference packed word: bit i set when pixel 16*w+i exceeds the threshold.
  function automatic logic [15:0] model_word(input int w, input logic [7:0] th);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = (mem[16*w + i] > th);
    return r;
  endfunction

  // ---------------- reference timeline / scoreboard ----------------
  // cyc numbers clock cycles; a start held during cycle s begins a run whose
  // cycle k = cyc - s is: READ pixel (k-1)%18 for phase 0..15, LAST at 16,
  // WRITE at 17, for word (k-1)/18.
  int   cyc = 0;
  bit   busy = 1'b0;
  int   start_cyc = 0;
  logic done_exp = 1'b0;
  logic [9:0] exp_q [$];

  always @(negedge clk) begin
    int k, p, w;
    logic e_rd, e_wr;
    if (rst) begin
      for (int g = 0; g < N_DUT; g++) begin
        chk($sformatf("u%0d.rst_rd", g),    mon_rd[g],    0);
        chk($sformatf("u%0d.rst_raddr", g), mon_raddr[g], 0);
        chk($sformatf("u%0d.rst_wr", g),    mon_wr[g],    0);
        chk($sformatf("u%0d.rst_waddr", g), mon_waddr[g], 0);
        chk($sformatf("u%0d.rst_do", g),    mon_do[g],    0);
        chk($sformatf("u%0d.rst_done", g),  mon_done[g],  0);
        chk($sformatf("u%0d.rst_state", g), mon_state[g], 0);
      end
      busy = 1'b0;
      done_exp = 1'b0;
      exp_q.delete();
    end else begin
      e_rd = 1'b0;
      e_wr = 1'b0;
      p = 0;
      w = 0;
      if (busy) begin
        k = cyc - start_cyc;
        p = (k - 1) % 18;
        w = (k - 1) / 18;
        e_rd = (p < 16);
        e_wr = (p == 17);
      end
      for (int g = 0; g < N_DUT; g++) begin
        chk($sformatf("u%0d.res_rd", g), mon_rd[g], e_rd);
        if (busy && p <= 16)
          chk($sformatf("u%0d.res_addr", g), mon_raddr[g], 16*w + ((p == 16) ? 15 : p));
        chk($sformatf("u%0d.sti_wr", g), mon_wr[g], e_wr);
        if (e_wr) begin
          chk($sformatf("u%0d.sti_addr", g), mon_waddr[g], exp_q[0]);
          chk($sformatf("u%0d.sti_do", g), mon_do[g], model_word(w, TH[g]));
        end
        chk($sformatf("u%0d.done", g), mon_done[g], done_exp);
      end
      if (e_wr) void'(exp_q.pop_front());
      if (start && !busy) begin
        busy = 1'b1;
        start_cyc = cyc;
        done_exp = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(10'(i));
      end else if (e_wr && w == 1023) begin
        busy = 1'b0;
        done_exp = 1'b1;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] edge_pixel();
    logic [7:0] e [7];
    e = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    return e[$urandom_range(0, 6)];
  endfunction

  // Regions: words 0-1 single-pixel corners, 2-255 first pixel 0x01,
  // 256-511 alternating 0x80/0x81, 512-767 zero, 768-1023 threshold edges.
  task automatic fill_mixed();
    for (int a = 0; a < 16384; a++) begin
      int w;
      w = a / 16;
      if (w < 2)        mem[a] = (a == 15) ? 8'hFF : ((a == 16) ? 8'h01 : 8'h00);
      else if (w < 256) mem[a] = (a % 16 == 0) ? 8'h01 : 8'h00;
      else if (w < 512) mem[a] = (a % 2 == 0) ? 8'h80 : 8'h81;
      else if (w < 768) mem[a] = 8'h00;
      else              mem[a] = edge_pixel();
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 16384; a++)
      mem[a] = ($urandom_range(0, 1) == 1) ? edge_pixel() : 8'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    rst = 1'b1;
    start = 1'b0;
    fill_mixed();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Run 1: full image; a start in the final WRITE cycle must be ignored.
    t0 = cyc;
    pulse_start();
    wait_cyc(t0 + 18432);
    for (int g = 0; g < N_DUT; g++) begin
      chk($sformatf("u%0d.last_wr", g), mon_wr[g], 1);
      chk($sformatf("u%0d.last_addr", g), mon_waddr[g], 1023);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // The 18432-cycle run is over: done is up and stays up.
    for (int g = 0; g < N_DUT; g++)
      chk($sformatf("u%0d.done_entry", g), mon_done[g], 1);
    repeat (4) @(posedge clk);
    #1;

    // Run 2: restart from DONE with random image and stray starts mid-run.
    fill_random();
    t0 = cyc;
    pulse_start();
    for (int g = 0; g < N_DUT; g++)
      chk($sformatf("u%0d.done_fall", g), mon_done[g], 0);
    while (cyc < t0 + 18000) begin
      repeat ($urandom_range(100, 700)) @(posedge clk);
      #1;
      if (cyc < t0 + 18000) pulse_start();
    end
    wait_cyc(t0 + 18436);

    // Run 3: reset in word 5, READ cycle 7, then a clean restart.
    fill_random();
    t0 = cyc;
    pulse_start();
    wait_cyc(t0 + 98);
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < N_DUT; g++) begin
      chk($sformatf("u%0d.abort_rd", g),    mon_rd[g],    0);
      chk($sformatf("u%0d.abort_raddr", g), mon_raddr[g], 0);
      chk($sformatf("u%0d.abort_wr", g),    mon_wr[g],    0);
      chk($sformatf("u%0d.abort_do", g),    mon_do[g],    0);
      chk($sformatf("u%0d.abort_done", g),  mon_done[g],  0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    t0 = cyc;
    pulse_start();
    wait_cyc(t0 + 18*3 + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the whole run is well under this bound.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
